// File: rtl/lcd_bus_if.sv
// Pin and register bundle between the CPU-side LCD register and the character-LCD bus.
// Handshake: the CPU flips i_io_lcd[16] while BUSY=0; the controller flips DONE (status[1]) to match on completion.
interface lcd_bus_if;
    logic [31:0] i_io_lcd;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_en;
    logic        o_lcd_on;
    logic [31:0] o_lcd_status;

    modport master (
        output i_io_lcd,
        input  o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_status
    );

    modport slave (
        input  i_io_lcd,
        output o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_status
    );
endinterface

// File: rtl/lcd_bus_ctrl.sv
// Character-LCD write sequencer: power-up wait, then one timed RS/DATA/EN write per REQ toggle.
// Every output comes straight from a register; o_dbg_state exposes the FSM state.
module lcd_bus_ctrl #(
    parameter int unsigned T_PWRUP     = 750000,
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_EN        = 12,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 2000,
    parameter int unsigned T_EXEC_LONG = 82000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    lcd_bus_if.slave   bus,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_IDLE  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_HOLD  = 3'd4,
        S_EXEC  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_next;
    logic [31:0] w_dur;

    logic        r_acc;
    logic        r_req_prev;
    logic        r_busy;
    logic        r_done;
    logic        r_ovr;
    logic        r_init;
    logic        r_rs;
    logic        r_en;
    logic        r_on;
    logic [7:0]  r_data;
    logic [7:0]  r_count;

    logic        w_req;
    logic        w_pending;
    logic        w_long;
    logic        w_last;
    logic        w_complete;

    assign w_req      = bus.i_io_lcd[16];
    assign w_pending  = (r_state == S_IDLE) && (w_req != r_acc);
    // Clear-display and return-home need the long execution wait.
    assign w_long     = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));
    assign w_last     = (r_cnt == w_dur - 32'd1);
    assign w_complete = (r_state == S_EXEC) && w_last;

    always_comb begin
        w_dur = 32'd1;
        case (r_state)
            S_PWRUP: w_dur = 32'(T_PWRUP);
            S_SETUP: w_dur = 32'(T_SETUP);
            S_PULSE: w_dur = 32'(T_EN);
            S_HOLD:  w_dur = 32'(T_HOLD);
            S_EXEC:  w_dur = w_long ? 32'(T_EXEC_LONG) : 32'(T_EXEC);
            default: w_dur = 32'd1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 32'd1;
        if (r_state == S_IDLE) begin
            w_cnt_next = '0;
            if (w_pending) begin
                w_state_next = S_SETUP;
            end
        end else if (w_last) begin
            w_cnt_next = '0;
            case (r_state)
                S_PWRUP: w_state_next = S_IDLE;
                S_SETUP: w_state_next = S_PULSE;
                S_PULSE: w_state_next = S_HOLD;
                S_HOLD:  w_state_next = S_EXEC;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_PWRUP;
            r_cnt      <= '0;
            r_acc      <= 1'b0;
            r_req_prev <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
            r_init     <= 1'b0;
            r_rs       <= 1'b0;
            r_data     <= 8'h00;
            r_en       <= 1'b0;
            r_on       <= 1'b0;
            r_count    <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_req_prev <= w_req;
            r_on       <= bus.i_io_lcd[31];
            // EN is registered from the next state so it is high exactly during PULSE.
            r_en       <= (w_state_next == S_PULSE);
            if (w_state_next == S_IDLE) begin
                r_init <= 1'b1;
            end
            if (w_pending) begin
                r_acc  <= w_req;
                r_rs   <= bus.i_io_lcd[9];
                r_data <= bus.i_io_lcd[7:0];
                r_busy <= 1'b1;
            end
            if (w_complete) begin
                r_done  <= r_acc;
                r_count <= r_count + 8'd1;
                r_busy  <= 1'b0;
            end
            if (r_busy && (w_req != r_req_prev)) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign bus.o_lcd_data   = r_data;
    assign bus.o_lcd_rs     = r_rs;
    assign bus.o_lcd_rw     = 1'b0;
    assign bus.o_lcd_en     = r_en;
    assign bus.o_lcd_on     = r_on;
    assign bus.o_lcd_status = {16'h0000, r_count, 4'h0, r_init, r_ovr, r_done, r_busy};
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Randomized bench for lcd_bus_ctrl: a transaction model pushes expected writes into a queue
// and a negedge monitor measures each BUSY window and compares it on completion.
module tb_lcd_bus_ctrl;

    localparam int T_PWRUP     = 10;
    localparam int T_SETUP     = 2;
    localparam int T_EN        = 4;
    localparam int T_HOLD      = 2;
    localparam int T_EXEC      = 8;
    localparam int T_EXEC_LONG = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;

    lcd_bus_if bus();

    lcd_bus_ctrl #(
        .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_EN(T_EN),
        .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rs;
        logic [7:0]  data;
        logic [7:0]  busy_len;
        logic [31:0] status;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   m_count = 0;
    bit   m_ovr   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int exec_len(input logic rs, input logic [7:0] d);
        if (!rs && d >= 8'd1 && d <= 8'd3) return T_EXEC_LONG;
        return T_EXEC;
    endfunction

    task automatic push_expect(input logic rs, input logic [7:0] d, input logic req);
        exp_t e;
        m_count    = (m_count + 1) % 256;
        e.rs       = rs;
        e.data     = d;
        e.busy_len = 8'(T_SETUP + T_EN + T_HOLD + exec_len(rs, d));
        e.status   = {16'h0000, 8'(m_count), 4'h0, 1'b1, m_ovr, req, 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.o_lcd_status[0] || !bus.o_lcd_status[3]) && n < 200) begin
            tick();
            n++;
        end
        check("wait_idle_busy", 32'(bus.o_lcd_status[0]), 32'd0);
    endtask

    task automatic issue(input logic rs, input logic [7:0] d, input bit dbl, input bit disturb);
        logic req_new;
        wait_idle();
        req_new = ~bus.i_io_lcd[16];
        if (dbl) m_ovr = 1'b1;
        push_expect(rs, d, req_new);
        bus.i_io_lcd[16]  = req_new;
        bus.i_io_lcd[9]   = rs;
        bus.i_io_lcd[7:0] = d;
        tick();
        check("accept_busy", 32'(bus.o_lcd_status[0]), 32'd1);
        check("setup_rs", 32'(bus.o_lcd_rs), 32'(rs));
        check("setup_data", 32'(bus.o_lcd_data), 32'(d));
        check("setup_en", 32'(bus.o_lcd_en), 32'd0);
        if (dbl) begin
            repeat (2) tick();
            bus.i_io_lcd[16] = ~req_new;
            tick();
            bus.i_io_lcd[16] = req_new;
        end
        if (disturb) begin
            tick();
            bus.i_io_lcd[9]   = ~rs;
            bus.i_io_lcd[7:0] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic pwrup_sequence(input bit expect_req);
        rst = 1'b0;
        for (int k = 1; k <= T_PWRUP; k++) begin
            tick();
            check("pwrup_init_done", 32'(bus.o_lcd_status[3]), 32'(k == T_PWRUP));
            check("pwrup_busy", 32'(bus.o_lcd_status[0]), 32'd0);
            check("pwrup_en", 32'(bus.o_lcd_en), 32'd0);
        end
        check("pwrup_status", bus.o_lcd_status, 32'h0000_0008);
        if (expect_req) begin
            tick();
            check("pending_after_pwrup", 32'(bus.o_lcd_status[0]), 32'd1);
        end
    endtask

    // Monitor: measures each BUSY window and scores it against the head of the queue.
    int bc, en_start, en_len;
    bit in_busy = 1'b0;
    bit rsd_bad;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            in_busy = 1'b0;
        end else if (bus.o_lcd_status[0]) begin
            if (!in_busy) begin
                in_busy  = 1'b1;
                bc       = 0;
                en_start = 0;
                en_len   = 0;
                rsd_bad  = 1'b0;
            end
            bc++;
            if (bus.o_lcd_en) begin
                en_len++;
                if (en_start == 0) en_start = bc;
            end
            if (bc <= T_SETUP + T_EN + T_HOLD) begin
                if (exp_q.size() == 0) rsd_bad = 1'b1;
                else if (bus.o_lcd_rs !== exp_q[0].rs || bus.o_lcd_data !== exp_q[0].data) rsd_bad = 1'b1;
            end
        end else if (in_busy) begin
            in_busy = 1'b0;
            check("completion_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("busy_len", 32'(bc), 32'(e.busy_len));
                check("en_rise_offset", 32'(en_start), 32'(T_SETUP + 1));
                check("en_len", 32'(en_len), 32'(T_EN));
                check("rs_data_held", 32'(rsd_bad), 32'd0);
                check("status_after_write", bus.o_lcd_status, e.status);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.i_io_lcd = 32'h0;
        tick();
        check("reset_status", bus.o_lcd_status, 32'h0);
        check("reset_en", 32'(bus.o_lcd_en), 32'd0);
        check("reset_on", 32'(bus.o_lcd_on), 32'd0);
        check("reset_rs", 32'(bus.o_lcd_rs), 32'd0);
        check("reset_data", 32'(bus.o_lcd_data), 32'd0);
        check("reset_rw", 32'(bus.o_lcd_rw), 32'd0);
        tick();
        pwrup_sequence(1'b0);

        // Data write with panel power on: i_io_lcd becomes 0x80010241.
        bus.i_io_lcd[31] = 1'b1;
        issue(1'b1, 8'h41, 1'b0, 1'b0);
        check("io_word", bus.i_io_lcd, 32'h8001_0241);
        check("lcd_on", 32'(bus.o_lcd_on), 32'd1);

        // Clear-display command takes the long execution wait.
        issue(1'b0, 8'h01, 1'b0, 1'b0);

        // Two REQ flips during BUSY: overrun, no extra request afterwards.
        issue(1'b1, 8'h55, 1'b1, 1'b1);
        wait_idle();
        repeat (3) tick();
        check("no_pending_after_overrun", 32'(bus.o_lcd_status[0]), 32'd0);
        check("overrun_sticky", 32'(bus.o_lcd_status[2]), 32'd1);

        bus.i_io_lcd[31] = 1'b0;
        tick();
        check("lcd_off", 32'(bus.o_lcd_on), 32'd0);

        for (int i = 0; i < 30; i++) begin
            logic       rs;
            logic [7:0] d;
            rs = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            issue(rs, d, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
        end

        // Reset during the EN pulse, with a request left pending across power-up.
        issue(1'b1, 8'h33, 1'b0, 1'b0);
        n = 0;
        while (!bus.o_lcd_en && n < 20) begin
            tick();
            n++;
        end
        check("en_before_reset", 32'(bus.o_lcd_en), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        m_count = 0;
        m_ovr   = 1'b0;
        tick();
        check("reset_mid_en", 32'(bus.o_lcd_en), 32'd0);
        check("reset_mid_status", bus.o_lcd_status, 32'h0);
        bus.i_io_lcd[16]  = 1'b1;
        bus.i_io_lcd[9]   = 1'b1;
        bus.i_io_lcd[7:0] = 8'h77;
        push_expect(1'b1, 8'h77, 1'b1);
        tick();
        pwrup_sequence(1'b1);

        // 255 more writes bring the post-reset total to 256.
        for (int i = 0; i < 255; i++) begin
            issue(1'($urandom_range(0, 1)), 8'($urandom_range(4, 255)), 1'b0, $urandom_range(0, 3) == 0);
        end
        wait_idle();
        tick();
        check("count_wrap", 32'(bus.o_lcd_status[15:8]), 32'd0);
        check("done_last_req", 32'(bus.o_lcd_status[1]), 32'(bus.i_io_lcd[16]));

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
